recover_2n_collector: RTL

- Sink-side companion of the 2N-point recovery butterfly stage. It receives that stage's registered output beats: a strobe plus a 4-lane col1 group, a 4-lane col2 group and a group index per column.
- Beats arrive in arbitrary group order. The block writes them into a ping-pong frame buffer.
- Each completed frame streams out one complex sample per cycle in natural order, under a valid/ready handshake.
- It sits between the recovery stage and the downstream consumer (DMA or next-stage loader).

---
 rtl/recover_2n_collector.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/recover_2n_collector.sv
`default_nettype none
// ============================================================================
//  Module   : recover_2n_collector
//  Purpose  : Collects out-of-order 8-sample beats from the 2N-point recovery
//             butterfly into a ping-pong frame buffer and streams each
//             completed frame out one complex sample per cycle in natural
//             order under a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module recover_2n_collector #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 11,
    parameter int FRAME_LEN   = 64,
    parameter int ADDR_W      = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [4*DATA_WIDTH-1:0] in_col1_r,
    input  logic [4*DATA_WIDTH-1:0] in_col1_i,
    input  logic [4*DATA_WIDTH-1:0] in_col2_r,
    input  logic [4*DATA_WIDTH-1:0] in_col2_i,
    input  logic [INDEX_WIDTH-1:0]  in_index_col1,
    input  logic [INDEX_WIDTH-1:0]  in_index_col2,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data_r,
    output logic [DATA_WIDTH-1:0]   m_data_i,
    output logic [ADDR_W-1:0]       m_addr,
    output logic                    m_last,
    output logic                    overflow,
    output logic                    index_err,
    input  logic                    clr_err
);

    localparam int BEATS = FRAME_LEN / 8;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [INDEX_WIDTH:0] GROUPS = (INDEX_WIDTH + 1)'(FRAME_LEN / 4);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_RUN  = 1'b1
    } drain_state_t;

    // Two banks stored back to back; bank select is the address MSB.
    logic [DATA_WIDTH-1:0] mem_re [2*FRAME_LEN];
    logic [DATA_WIDTH-1:0] mem_im [2*FRAME_LEN];

    bank_state_t  bank_state_q [2];
    bank_state_t  bank_state_d [2];
    logic         fill_q,      fill_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    drain_state_t drain_state_q, drain_state_d;
    logic         drain_ptr_q, drain_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic         rd_more_q,   rd_more_d;
    logic         m_valid_q,   m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_r_q, m_data_r_d;
    logic [DATA_WIDTH-1:0] m_data_i_q, m_data_i_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic         m_last_q,    m_last_d;
    logic         overflow_q,  overflow_d;
    logic         index_err_q, index_err_d;

    logic w_idx_bad;
    logic w_fill_open;
    logic w_wr_en;
    logic w_drain_done;
    logic w_drain_free;
    logic w_load;
    logic [DATA_WIDTH-1:0] w_rd_r;
    logic [DATA_WIDTH-1:0] w_rd_i;

    assign w_idx_bad    = ({1'b0, in_index_col1} >= GROUPS) || ({1'b0, in_index_col2} >= GROUPS);
    assign w_fill_open  = (bank_state_q[fill_q] == BANK_EMPTY) || (bank_state_q[fill_q] == BANK_FILLING);
    assign w_wr_en      = in_valid && !w_idx_bad && w_fill_open;
    assign w_drain_done = m_valid_q && m_ready && m_last_q;
    assign w_drain_free = (drain_state_q == DRAIN_IDLE) || w_drain_done;
    assign w_load       = rd_more_q && (!m_valid_q || m_ready);
    assign w_rd_r       = mem_re[{drain_ptr_q, rd_addr_q}];
    assign w_rd_i       = mem_im[{drain_ptr_q, rd_addr_q}];

    // Beat write: col2 lanes are written after col1 so a collision keeps col2.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                mem_re[{fill_q, in_index_col1[ADDR_W-3:0], 2'(k)}] <= in_col1_r[k*DATA_WIDTH +: DATA_WIDTH];
                mem_im[{fill_q, in_index_col1[ADDR_W-3:0], 2'(k)}] <= in_col1_i[k*DATA_WIDTH +: DATA_WIDTH];
                mem_re[{fill_q, in_index_col2[ADDR_W-3:0], 2'(k)}] <= in_col2_r[k*DATA_WIDTH +: DATA_WIDTH];
                mem_im[{fill_q, in_index_col2[ADDR_W-3:0], 2'(k)}] <= in_col2_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: bank bookkeeping, fill counter, drain sequencing, output register.
    always_comb begin
        bank_state_d  = bank_state_q;
        fill_d        = fill_q;
        beat_cnt_d    = beat_cnt_q;
        drain_state_d = drain_state_q;
        drain_ptr_d   = drain_ptr_q;
        rd_addr_d     = rd_addr_q;
        rd_more_d     = rd_more_q;
        m_valid_d     = m_valid_q;
        m_data_r_d    = m_data_r_q;
        m_data_i_d    = m_data_i_q;
        m_addr_d      = m_addr_q;
        m_last_d      = m_last_q;
        overflow_d    = (overflow_q && !clr_err) || (in_valid && !w_idx_bad && !w_fill_open);
        index_err_d   = (index_err_q && !clr_err) || (in_valid && w_idx_bad);

        // Fill side: the frame completes on beat count, not on address coverage.
        if (w_wr_en) begin
            if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                bank_state_d[fill_q] = BANK_FULL;
                beat_cnt_d           = '0;
                fill_d               = !fill_q;
            end else begin
                bank_state_d[fill_q] = BANK_FILLING;
                beat_cnt_d           = beat_cnt_q + CNT_W'(1);
            end
        end

        // Output register: load the next sample whenever the slot is free or being taken.
        if (w_load) begin
            m_valid_d  = 1'b1;
            m_data_r_d = w_rd_r;
            m_data_i_d = w_rd_i;
            m_addr_d   = rd_addr_q;
            m_last_d   = (rd_addr_q == ADDR_W'(FRAME_LEN - 1));
            rd_addr_d  = rd_addr_q + ADDR_W'(1);
            if (rd_addr_q == ADDR_W'(FRAME_LEN - 1)) begin
                rd_more_d = 1'b0;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        // Final transfer of a frame releases its bank to the fill side.
        if (w_drain_done) begin
            bank_state_d[drain_ptr_q] = BANK_EMPTY;
            drain_ptr_d               = !drain_ptr_q;
            drain_state_d             = DRAIN_IDLE;
        end

        // Start the oldest full bank; checked in the release cycle too to limit gaps to one.
        if (w_drain_free && (bank_state_q[drain_ptr_d] == BANK_FULL)) begin
            bank_state_d[drain_ptr_d] = BANK_DRAINING;
            drain_state_d             = DRAIN_RUN;
            rd_addr_d                 = '0;
            rd_more_d                 = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            fill_q          <= 1'b0;
            beat_cnt_q      <= '0;
            drain_state_q   <= DRAIN_IDLE;
            drain_ptr_q     <= 1'b0;
            rd_addr_q       <= '0;
            rd_more_q       <= 1'b0;
            m_valid_q       <= 1'b0;
            m_data_r_q      <= '0;
            m_data_i_q      <= '0;
            m_addr_q        <= '0;
            m_last_q        <= 1'b0;
            overflow_q      <= 1'b0;
            index_err_q     <= 1'b0;
        end else begin
            bank_state_q    <= bank_state_d;
            fill_q          <= fill_d;
            beat_cnt_q      <= beat_cnt_d;
            drain_state_q   <= drain_state_d;
            drain_ptr_q     <= drain_ptr_d;
            rd_addr_q       <= rd_addr_d;
            rd_more_q       <= rd_more_d;
            m_valid_q       <= m_valid_d;
            m_data_r_q      <= m_data_r_d;
            m_data_i_q      <= m_data_i_d;
            m_addr_q        <= m_addr_d;
            m_last_q        <= m_last_d;
            overflow_q      <= overflow_d;
            index_err_q     <= index_err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data_r  = m_data_r_q;
    assign m_data_i  = m_data_i_q;
    assign m_addr    = m_addr_q;
    assign m_last    = m_last_q;
    assign overflow  = overflow_q;
    assign index_err = index_err_q;

endmodule
`default_nettype wire
